bus_datapath_mc: RTL and testbench
==================================

Name: bus_datapath_mc

Overview:
- Parametrised next-generation single-bus CPU datapath: register file, PC, IR, MAR, MDR, HI/LO, Y, Z (high/low) and one shared bus, selected by a one-hot drive vector.
- Adds an integrated ALU with single-cycle logic/arithmetic ops and multi-cycle unsigned multiply/divide, a start/busy/done handshake, and bus-contention detection.
- Sits between the control unit (drives all strobes) and the memory interface (Mdatain, MAR).

Parameters:
- WIDTH, 32, datapath word width (≥8).
- NREGS, 16, general registers R0..R(NREGS-1) (2..32).

Ports:
- Clock  in  1  rising-edge clock.
- clear  in  1  asynchronous active-low reset.
- Rout  in  NREGS  one-hot register drive; bit i drives Ri onto the bus.
- Rin  in  NREGS  register load enables; bit i loads Ri from the bus.
- src_out  in  7  {InPortout, MDRout, LOout, HIout, Zhighout, Zlowout, PCout} drive strobes.
- PCin, IncPC, IRin, MARin, MDRin, Read, Yin, HIin, LOin  in  1 each  load strobes.
- Mdatain  in  WIDTH  memory read data.
- InPort  in  WIDTH  external input port value.
- op  in  3  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR, 6 MUL, 7 DIV.
- start  in  1  launch ALU op on A=Y, B=bus.
- busy  out  1  multi-cycle op in progress.
- done  out  1  one-cycle pulse when Z is written.
- div0  out  1  sticky; set by DIV with B=0.
- bus_conflict  out  1  combinational: more than one driver this cycle.
- bus  out  WIDTH  current bus value.
- IR_q, MAR_q  out  WIDTH  IR and MAR contents.

Behaviour:
- Reset (clear=0, async): all registers, Z, Y, MAR, MDR, IR, PC, HI, LO = 0. busy, done, div0 = 0. Internal multi-cycle state returns to IDLE. An in-flight op is abandoned with no Z write.
- Bus (combinational): exactly one driver gives that source's value. Zero drivers gives 0. Two or more drivers give 0 and bus_conflict=1; all loads in that cycle still capture 0. The ALU never drives the bus directly.
- Loads occur on the rising edge from the bus when the strobe is high.
- MDR loads Mdatain if Read=1, else the bus, when MDRin=1.
- PC: PCin has priority; otherwise IncPC gives PC+1 (mod 2^WIDTH).
- Z is written only by the ALU. Z has no Zin strobes.
- ALU FSM states: IDLE, MUL_RUN, DIV_RUN, FIN.
  - IDLE with start=1 and op 0-5: on that edge Zlow=result; Zhigh=0, except SUB sets Zhigh to all-ones on borrow and ADD sets Zhigh=carry. done=1 for the next cycle. FSM stays in IDLE.
  - SHL/SHR: shift amount is B[log2(WIDTH)-1:0]; logical shift, zero-fill.
  - IDLE with start=1 and op 6: latch A and B, busy=1, go to MUL_RUN. Shift-add for WIDTH cycles, then FIN. FIN writes {Zhigh,Zlow} = A*B (2·WIDTH bits, unsigned), pulses done, clears busy, returns to IDLE. Latency from start edge to done: WIDTH+1 cycles.
  - op 7 with B≠0: restoring division for WIDTH cycles in DIV_RUN, then FIN. Zlow=quotient, Zhigh=remainder. Same latency as MUL.
  - op 7 with B=0: no DIV_RUN. On the start edge Zlow = all-ones, Zhigh = A, div0=1, done pulses next cycle.
- start while busy=1 is ignored, with no queueing. Y and bus may change during busy because operands are latched.
- Reading Z during busy returns the previous Z value.
- div0 clears only on reset.

Test Plan:
- Reset mid-MUL: Y=7, bus=R1=9, op=6, start, then clear=0 after 5 cycles → Z=0, busy=0, no done. A new MUL afterwards gives Zlow=63 after 33 cycles (WIDTH=32).
- ADD carry: Y=0xFFFFFFFF, bus=1, op=0, start → next cycle Zlow=0, Zhigh=1, done=1 for one cycle.
- DIV: Y=100, bus=7, op=7 → done at start+33, Zlow=14, Zhigh=2. DIV with bus=0 → Zlow=0xFFFFFFFF, Zhigh=100, div0=1.
- MUL wide: Y=0x80000000, bus=4 → Zhigh=2, Zlow=0. A second start during busy is ignored.
- Bus conflict: Rout[3]=1 with PCout=1 and Rin[5]=1 → bus_conflict=1, R5=0. MDRin with Read=1, Mdatain=0xA5 → MDR=0xA5, then MDRout puts 0xA5 on the bus.
- PC priority: PCin and IncPC together with bus=0x40 → PC=0x40. IncPC alone → 0x41. Repeat with NREGS=8, WIDTH=16: R7 loads and drives correctly, and MUL latency is 17.

Source files
------------

// File: rtl/bus_datapath_mc.sv
// ----------------------------------------------------------------------------
// bus_datapath_mc
//
// Single-bus CPU datapath with an integrated ALU. The register file (R0..Rn),
// PC, IR, MAR, MDR, HI, LO, Y and the split Z register share one bus. Exactly
// one drive strobe places a source on the bus. With no strobe the bus reads 0.
// With several strobes it also reads 0 and bus_conflict is raised.
//
// The ALU takes A from Y and B from the bus. Only the ALU writes Z.
//
// Ports:
//   Clock, clear          rising-edge clock, asynchronous active-low reset
//   Rout / Rin            one-hot register drive, register load enables
//   src_out[6:0]          {InPortout, MDRout, LOout, HIout, Zhighout,
//                          Zlowout, PCout}
//   PCin, IncPC, IRin,    load strobes (PCin has priority over IncPC;
//   MARin, MDRin, Read,    MDRin loads Mdatain when Read=1, else the bus)
//   Yin, HIin, LOin
//   Mdatain, InPort       memory read data, external input port
//   op, start             ALU opcode and launch strobe
//   busy, done, div0      ALU status (div0 is sticky until reset)
//   bus_conflict, bus     bus status and bus value
//   IR_q, MAR_q           IR and MAR contents
//   alu_state             ALU FSM state (0 IDLE, 1 MUL_RUN, 2 DIV_RUN, 3 FIN)
//
// ALU handshake: start is sampled only while busy=0. A single-cycle op, or a
// divide by zero, writes Z on the start edge. A multiply or divide latches
// its operands on the start edge and raises busy. It writes Z on the edge
// WIDTH+1 cycles later, and busy drops on that same edge. done is high for
// exactly one cycle after each Z write. A start while busy=1 is dropped.
// ----------------------------------------------------------------------------
module bus_datapath_mc #(
   parameter int WIDTH = 32,
   parameter int NREGS = 16
) (
   input  logic               Clock,
   input  logic               clear,
   input  logic [NREGS-1:0]   Rout,
   input  logic [NREGS-1:0]   Rin,
   input  logic [6:0]         src_out,
   input  logic               PCin,
   input  logic               IncPC,
   input  logic               IRin,
   input  logic               MARin,
   input  logic               MDRin,
   input  logic               Read,
   input  logic               Yin,
   input  logic               HIin,
   input  logic               LOin,
   input  logic [WIDTH-1:0]   Mdatain,
   input  logic [WIDTH-1:0]   InPort,
   input  logic [2:0]         op,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               div0,
   output logic               bus_conflict,
   output logic [WIDTH-1:0]   bus,
   output logic [WIDTH-1:0]   IR_q,
   output logic [WIDTH-1:0]   MAR_q,
   output logic [1:0]         alu_state
);

   localparam int SHW  = $clog2(WIDTH);
   localparam int CNTW = $clog2(WIDTH);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      DIV_RUN = 2'd2,
      FIN     = 2'd3
   } alu_state_t;

   // Architectural registers
   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] mdr_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] y_q;
   logic [WIDTH-1:0] zhi_q;
   logic [WIDTH-1:0] zlo_q;

   // ---------------------------------------------------------------------
   // Bus: AND-OR of every driven source. The result is used only when
   // exactly one driver is active.
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] src_val [7];
   logic [WIDTH-1:0] bus_or;
   logic [5:0]       drv_cnt;

   assign src_val[0] = pc_q;
   assign src_val[1] = zlo_q;
   assign src_val[2] = zhi_q;
   assign src_val[3] = hi_q;
   assign src_val[4] = lo_q;
   assign src_val[5] = mdr_q;
   assign src_val[6] = InPort;

   always_comb begin
      drv_cnt = '0;
      bus_or  = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (Rout[i]) begin
            drv_cnt = drv_cnt + 6'd1;
            bus_or  = bus_or | regs[i];
         end
      end
      for (int j = 0; j < 7; j++) begin
         if (src_out[j]) begin
            drv_cnt = drv_cnt + 6'd1;
            bus_or  = bus_or | src_val[j];
         end
      end
   end

   assign bus          = (drv_cnt == 6'd1) ? bus_or : '0;
   assign bus_conflict = (drv_cnt > 6'd1);

   // ---------------------------------------------------------------------
   // Register loads
   // ---------------------------------------------------------------------
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (Rin[i]) regs[i] <= bus;
         end
      end
   end

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         pc_q  <= '0;
         IR_q  <= '0;
         MAR_q <= '0;
         mdr_q <= '0;
         y_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         if (PCin)       pc_q <= bus;
         else if (IncPC) pc_q <= pc_q + WIDTH'(1);
         if (IRin)  IR_q  <= bus;
         if (MARin) MAR_q <= bus;
         if (MDRin) mdr_q <= Read ? Mdatain : bus;
         if (Yin)   y_q   <= bus;
         if (HIin)  hi_q  <= bus;
         if (LOin)  lo_q  <= bus;
      end
   end

   // ---------------------------------------------------------------------
   // ALU: single-cycle results
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH:0]   add_full;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] res_lo;
   logic [WIDTH-1:0] res_hi;

   assign alu_a    = y_q;
   assign alu_b    = bus;
   assign add_full = {1'b0, alu_a} + {1'b0, alu_b};
   assign shamt    = alu_b[SHW-1:0];

   always_comb begin
      res_lo = '0;
      res_hi = '0;
      case (op)
         3'd0: begin
            res_lo = add_full[WIDTH-1:0];
            res_hi = {{(WIDTH-1){1'b0}}, add_full[WIDTH]};
         end
         3'd1: begin
            res_lo = alu_a - alu_b;
            res_hi = (alu_a < alu_b) ? {WIDTH{1'b1}} : '0;
         end
         3'd2: res_lo = alu_a & alu_b;
         3'd3: res_lo = alu_a | alu_b;
         3'd4: res_lo = alu_a << shamt;
         3'd5: res_lo = alu_a >> shamt;
         default: begin
            res_lo = '0;
            res_hi = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // ALU: multi-cycle engine. prod_q serves both long operations.
   // For a multiply it holds {partial product, multiplier}.
   // For a divide it holds {remainder, dividend/quotient}.
   // At FIN, prod_q upper half goes to Zhigh and lower half to Zlow.
   // opnd_q holds the multiplicand or the divisor.
   // ---------------------------------------------------------------------
   alu_state_t       state;
   logic [2*WIDTH-1:0] prod_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [CNTW-1:0]    cnt_q;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     r_shift;
   logic               r_ge;
   logic [WIDTH-1:0]   r_diff;
   logic [2*WIDTH-1:0] div_next;

   // Shift-add step: add the multiplicand into the high half when the
   // current multiplier bit is set, then shift the whole product right.
   assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                   + (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
   assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

   // Restoring step: shift the next dividend bit into the remainder and
   // subtract the divisor if it fits. The remainder stays below the
   // divisor, so the difference fits in WIDTH bits.
   assign r_shift  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
   assign r_ge     = (r_shift >= {1'b0, opnd_q});
   assign r_diff   = r_shift[WIDTH-1:0] - opnd_q;
   assign div_next = r_ge ? {r_diff, prod_q[WIDTH-2:0], 1'b1}
                          : {r_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         div0   <= 1'b0;
         zhi_q  <= '0;
         zlo_q  <= '0;
         prod_q <= '0;
         opnd_q <= '0;
         cnt_q  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (op == 3'd6) begin
                     opnd_q <= alu_a;
                     prod_q <= {{WIDTH{1'b0}}, alu_b};
                     cnt_q  <= '0;
                     busy   <= 1'b1;
                     state  <= MUL_RUN;
                  end else if (op == 3'd7) begin
                     if (alu_b == '0) begin
                        zlo_q <= {WIDTH{1'b1}};
                        zhi_q <= alu_a;
                        div0  <= 1'b1;
                        done  <= 1'b1;
                     end else begin
                        opnd_q <= alu_b;
                        prod_q <= {{WIDTH{1'b0}}, alu_a};
                        cnt_q  <= '0;
                        busy   <= 1'b1;
                        state  <= DIV_RUN;
                     end
                  end else begin
                     zlo_q <= res_lo;
                     zhi_q <= res_hi;
                     done  <= 1'b1;
                  end
               end
            end
            MUL_RUN: begin
               prod_q <= mul_next;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) state <= FIN;
            end
            DIV_RUN: begin
               prod_q <= div_next;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) state <= FIN;
            end
            FIN: begin
               zhi_q <= prod_q[2*WIDTH-1:WIDTH];
               zlo_q <= prod_q[WIDTH-1:0];
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign alu_state = state;

endmodule

// File: tb/tb_bus_datapath_mc.sv
module tb_bus_datapath_mc;

   localparam logic [6:0] PCO  = 7'b0000001;
   localparam logic [6:0] ZLO  = 7'b0000010;
   localparam logic [6:0] ZHI  = 7'b0000100;
   localparam logic [6:0] HIO  = 7'b0001000;
   localparam logic [6:0] LOO  = 7'b0010000;
   localparam logic [6:0] MDRO = 7'b0100000;
   localparam logic [6:0] INO  = 7'b1000000;

   // ---------------- clock / reset ----------------
   logic Clock;
   logic clear;

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // ---------------- main instance (WIDTH=32, NREGS=16) ----------------
   logic [15:0] Rout, Rin;
   logic [6:0]  src_out;
   logic        PCin, IncPC, IRin, MARin, MDRin, Read, Yin, HIin, LOin;
   logic [31:0] Mdatain, InPort;
   logic [2:0]  op;
   logic        start;
   logic        busy, done, div0, bus_conflict;
   logic [31:0] bus, IR_q, MAR_q;
   logic [1:0]  alu_state;

   bus_datapath_mc #(.WIDTH(32), .NREGS(16)) dut (
      .Clock(Clock), .clear(clear), .Rout(Rout), .Rin(Rin), .src_out(src_out),
      .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
      .Read(Read), .Yin(Yin), .HIin(HIin), .LOin(LOin), .Mdatain(Mdatain),
      .InPort(InPort), .op(op), .start(start), .busy(busy), .done(done),
      .div0(div0), .bus_conflict(bus_conflict), .bus(bus), .IR_q(IR_q),
      .MAR_q(MAR_q), .alu_state(alu_state)
   );

   // ---------------- small instance (WIDTH=16, NREGS=8) ----------------
   logic [7:0]  s_Rout, s_Rin;
   logic [6:0]  s_src_out;
   logic        s_Yin;
   logic [15:0] s_InPort;
   logic [2:0]  s_op;
   logic        s_start;
   logic        s_busy, s_done, s_div0, s_bus_conflict;
   logic [15:0] s_bus, s_IR_q, s_MAR_q;
   logic [1:0]  s_alu_state;

   bus_datapath_mc #(.WIDTH(16), .NREGS(8)) dut_s (
      .Clock(Clock), .clear(clear), .Rout(s_Rout), .Rin(s_Rin),
      .src_out(s_src_out), .PCin(1'b0), .IncPC(1'b0), .IRin(1'b0),
      .MARin(1'b0), .MDRin(1'b0), .Read(1'b0), .Yin(s_Yin), .HIin(1'b0),
      .LOin(1'b0), .Mdatain(16'h0000), .InPort(s_InPort), .op(s_op),
      .start(s_start), .busy(s_busy), .done(s_done), .div0(s_div0),
      .bus_conflict(s_bus_conflict), .bus(s_bus), .IR_q(s_IR_q),
      .MAR_q(s_MAR_q), .alu_state(s_alu_state)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle_ctl();
      Rout = '0; Rin = '0; src_out = '0;
      PCin = 0; IncPC = 0; IRin = 0; MARin = 0; MDRin = 0; Read = 0;
      Yin = 0; HIin = 0; LOin = 0; start = 0;
   endtask

   task automatic put_bus(input logic [31:0] v);
      src_out = INO;
      InPort  = v;
   endtask

   task automatic load_reg(input int i, input logic [31:0] v);
      idle_ctl();
      put_bus(v);
      Rin[i] = 1'b1;
      tick();
      idle_ctl();
   endtask

   task automatic load_y(input logic [31:0] v);
      idle_ctl();
      put_bus(v);
      Yin = 1'b1;
      tick();
      idle_ctl();
   endtask

   task automatic check_src(input string tag, input logic [6:0] sel,
                            input logic [31:0] exp);
      idle_ctl();
      src_out = sel;
      #1;
      check(tag, bus, exp);
      src_out = '0;
   endtask

   task automatic check_reg(input string tag, input int i,
                            input logic [31:0] exp);
      idle_ctl();
      Rout[i] = 1'b1;
      #1;
      check(tag, bus, exp);
      Rout = '0;
   endtask

   task automatic alu_start(input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] o);
      load_y(a);
      put_bus(b);
      op    = o;
      start = 1'b1;
      tick();
      idle_ctl();
   endtask

   // Counts edges after the start edge until done is seen, bounded by max.
   task automatic wait_done(input int max, output int n);
      n = 0;
      while (!done && n < max) begin
         tick();
         n++;
      end
   endtask

   // ---------------- single-cycle op vectors ----------------
   typedef struct {
      logic [2:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
   } vec_t;

   vec_t vecs [10] = '{
      '{3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001},
      '{3'd0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 32'h0000_0000},
      '{3'd1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 32'hFFFF_FFFF},
      '{3'd1, 32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 32'h0000_0000},
      '{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0000_0000},
      '{3'd3, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 32'h0000_0000},
      '{3'd4, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32'h0000_0000},
      '{3'd4, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030, 32'h0000_0000},
      '{3'd5, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 32'h0000_0000},
      '{3'd5, 32'hF000_0000, 32'h0000_0044, 32'h0F00_0000, 32'h0000_0000}
   };

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int n;
      int ndone;

      idle_ctl();
      Mdatain = '0; InPort = '0; op = '0;
      s_Rout = '0; s_Rin = '0; s_src_out = '0; s_Yin = 0;
      s_InPort = '0; s_op = '0; s_start = 0;
      clear = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_div0", div0, 0);
      check("rst_ir", IR_q, 0);
      check("rst_mar", MAR_q, 0);
      check("rst_state", alu_state, 0);
      clear = 1'b1;
      tick();
      check_src("rst_pc", PCO, 0);
      check_src("rst_zlo", ZLO, 0);
      check("idle_bus_zero", bus, 0);

      // Single-cycle ALU ops
      for (int k = 0; k < 10; k++) begin
         alu_start(vecs[k].a, vecs[k].b, vecs[k].o);
         check($sformatf("op%0d_done_%0d", vecs[k].o, k), done, 1);
         check_src($sformatf("op%0d_zlo_%0d", vecs[k].o, k), ZLO, vecs[k].lo);
         check_src($sformatf("op%0d_zhi_%0d", vecs[k].o, k), ZHI, vecs[k].hi);
         tick();
         check($sformatf("op%0d_done_drop_%0d", vecs[k].o, k), done, 0);
      end

      // Divide 100/7
      alu_start(32'd100, 32'd7, 3'd7);
      check("div_busy", busy, 1);
      wait_done(60, n);
      check("div_latency", n, 33);
      check_src("div_quot", ZLO, 32'd14);
      check_src("div_rem", ZHI, 32'd2);
      check("div_no_div0", div0, 0);
      check("div_busy_clear", busy, 0);

      // Divide by zero
      alu_start(32'd100, 32'd0, 3'd7);
      check("div0_done", done, 1);
      check("div0_flag", div0, 1);
      check("div0_busy", busy, 0);
      check_src("div0_zlo", ZLO, 32'hFFFF_FFFF);
      check_src("div0_zhi", ZHI, 32'd100);

      // Wide multiply with an ignored start during busy
      alu_start(32'h8000_0000, 32'd4, 3'd6);
      tick();
      tick();
      check_src("mul_busy_zlo_old", ZLO, 32'hFFFF_FFFF);
      put_bus(32'd5);
      op    = 3'd0;
      start = 1'b1;
      tick();
      idle_ctl();
      check("mul_ignored_start", done, 0);
      check("mul_busy", busy, 1);
      wait_done(60, n);
      check("mul_latency", n + 3, 33);
      check_src("mul_zhi", ZHI, 32'd2);
      check_src("mul_zlo", ZLO, 32'd0);
      tick();
      check("mul_done_pulse", done, 0);
      check("div0_sticky", div0, 1);

      // Bus conflict
      load_reg(3, 32'h11);
      load_reg(5, 32'h55);
      put_bus(32'h22);
      PCin = 1'b1;
      tick();
      idle_ctl();
      Rout[3] = 1'b1;
      src_out = PCO;
      Rin[5]  = 1'b1;
      #1;
      check("conflict_flag", bus_conflict, 1);
      check("conflict_bus", bus, 0);
      tick();
      idle_ctl();
      check_reg("conflict_r5", 5, 32'h0);
      check_reg("r3_kept", 3, 32'h11);
      check("conflict_clear", bus_conflict, 0);

      // MDR sources
      put_bus(32'h33);
      Mdatain = 32'hA5;
      Read    = 1'b1;
      MDRin   = 1'b1;
      tick();
      idle_ctl();
      check_src("mdr_read", MDRO, 32'hA5);
      put_bus(32'h77);
      MDRin = 1'b1;
      tick();
      idle_ctl();
      check_src("mdr_bus", MDRO, 32'h77);

      // PC priority, increment and wrap
      put_bus(32'h40);
      PCin  = 1'b1;
      IncPC = 1'b1;
      tick();
      idle_ctl();
      check_src("pc_priority", PCO, 32'h40);
      IncPC = 1'b1;
      tick();
      idle_ctl();
      check_src("pc_inc", PCO, 32'h41);
      put_bus(32'hFFFF_FFFF);
      PCin = 1'b1;
      tick();
      idle_ctl();
      IncPC = 1'b1;
      tick();
      idle_ctl();
      check_src("pc_wrap", PCO, 32'h0);

      // IR, MAR, HI, LO
      put_bus(32'hDEAD_BEEF);
      IRin  = 1'b1;
      MARin = 1'b1;
      tick();
      idle_ctl();
      check("ir_load", IR_q, 32'hDEAD_BEEF);
      check("mar_load", MAR_q, 32'hDEAD_BEEF);
      put_bus(32'h1234);
      HIin = 1'b1;
      tick();
      idle_ctl();
      put_bus(32'h5678);
      LOin = 1'b1;
      tick();
      idle_ctl();
      check_src("hi_load", HIO, 32'h1234);
      check_src("lo_load", LOO, 32'h5678);

      // Reset in the middle of a multiply
      load_reg(1, 32'd9);
      load_y(32'd7);
      Rout[1] = 1'b1;
      op      = 3'd6;
      start   = 1'b1;
      tick();
      idle_ctl();
      check("rmul_busy", busy, 1);
      repeat (4) tick();
      clear = 1'b0;
      #1;
      check("rmul_busy_rst", busy, 0);
      check("rmul_done_rst", done, 0);
      check("rmul_state_rst", alu_state, 0);
      check("rmul_div0_rst", div0, 0);
      #1;
      clear = 1'b1;
      check_src("rmul_zlo", ZLO, 32'h0);
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (done) ndone++;
      end
      check("rmul_no_done", ndone, 0);
      check_src("rmul_zlo_after", ZLO, 32'h0);
      check_reg("rmul_r1_rst", 1, 32'h0);

      alu_start(32'd7, 32'd9, 3'd6);
      wait_done(60, n);
      check("mul2_latency", n, 33);
      check_src("mul2_zlo", ZLO, 32'd63);
      check_src("mul2_zhi", ZHI, 32'd0);

      // Small instance: R7 path and MUL latency of WIDTH+1
      s_src_out = INO;
      s_InPort  = 16'hBEEF;
      s_Rin     = 8'h80;
      tick();
      s_Rin     = '0;
      s_src_out = '0;
      s_Rout    = 8'h80;
      #1;
      check("s_r7", s_bus, 16'hBEEF);
      s_Rout    = '0;
      s_src_out = INO;
      s_InPort  = 16'h1234;
      s_Yin     = 1'b1;
      tick();
      s_Yin     = 1'b0;
      s_InPort  = 16'h0010;
      s_op      = 3'd6;
      s_start   = 1'b1;
      tick();
      s_start   = 1'b0;
      s_src_out = '0;
      n = 0;
      while (!s_done && n < 40) begin
         tick();
         n++;
      end
      check("s_mul_latency", n, 17);
      s_src_out = ZLO;
      #1;
      check("s_mul_zlo", s_bus, 16'h2340);
      s_src_out = ZHI;
      #1;
      check("s_mul_zhi", s_bus, 16'h0001);
      s_src_out = '0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
